// File: rtl/pipe_pkg.sv
// Shared pipeline constants: latch condition codes, special register addresses
// and the hazard unit FSM state encoding.
package pipe_pkg;
  localparam logic [1:0] COND_FLOW  = 2'b00;
  localparam logic [1:0] COND_STALL = 2'b01;
  localparam logic [1:0] COND_ZERO  = 2'b10;

  localparam logic [6:0] NULL_ADDR = 7'h60;
  localparam logic [6:0] HI_ADDR   = 7'h40;
  localparam logic [6:0] LO_ADDR   = 7'h41;
  localparam logic [6:0] HILO_ADDR = 7'h42;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;
endpackage

// File: rtl/fwd_port_mux.sv
// One ID read port: matches its address against EX/MEM destinations and
// picks the forwarded operand, EX first.
module fwd_port_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [ADDR_W-1:0] me_waddr,
  input  logic              me_load,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic [DATA_W-1:0] me_wdata,
  input  logic [DATA_W-1:0] me_hi,
  input  logic [DATA_W-1:0] me_lo,
  input  logic [DATA_W-1:0] me_mem_data,
  output logic              ex_hit,
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  logic me_hit;

  // A HILO pair write satisfies a read of either half.
  function automatic logic addr_match(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa);
    return (ra != NULL_ADDR) &&
           ((ra == wa) || ((wa == HILO_ADDR) && ((ra == HI_ADDR) || (ra == LO_ADDR))));
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [ADDR_W-1:0] wa,
                                             input logic [DATA_W-1:0] w,
                                             input logic [DATA_W-1:0] hi,
                                             input logic [DATA_W-1:0] lo);
    if (wa == HI_ADDR)        return hi;
    else if (wa == LO_ADDR)   return lo;
    else if (wa == HILO_ADDR) return (raddr == HI_ADDR) ? hi : lo;
    else                      return w;
  endfunction

  assign ex_hit = addr_match(raddr, ex_waddr);
  assign me_hit = addr_match(raddr, me_waddr);
  assign hit    = ex_hit | me_hit;

  always_comb begin
    data = '0;
    if (ex_hit)      data = pick(ex_waddr, ex_wdata, ex_hi, ex_lo);
    else if (me_hit) data = pick(me_waddr, me_load ? me_mem_data : me_wdata, me_hi, me_lo);
  end
endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding beside ID: per-latch conditions,
// load-use/flush/mul-div stalls, mul/div watchdog and stall-cycle counter.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int NUM_RD    = 2,
  parameter int NUM_LATCH = 6,
  parameter int MD_MAX    = 64,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_stall,
  input  logic [NUM_RD*ADDR_W-1:0] id_raddr,
  input  logic [ADDR_W-1:0]        ex_waddr,
  input  logic [ADDR_W-1:0]        me_waddr,
  input  logic                     ex_load,
  input  logic                     me_load,
  input  logic [DATA_W-1:0]        ex_wdata,
  input  logic [DATA_W-1:0]        me_wdata,
  input  logic [DATA_W-1:0]        ex_hi,
  input  logic [DATA_W-1:0]        ex_lo,
  input  logic [DATA_W-1:0]        me_hi,
  input  logic [DATA_W-1:0]        me_lo,
  input  logic [DATA_W-1:0]        me_mem_data,
  input  logic                     br_flush,
  input  logic                     md_start,
  input  logic                     md_done,
  output logic [NUM_LATCH*2-1:0]   cond,
  output logic [NUM_RD-1:0]        fwd_valid,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic                     md_timeout,
  output logic [CNT_W-1:0]         stall_count
);
  localparam int MDC_W = $clog2(MD_MAX + 1);
  localparam logic [MDC_W-1:0] CNT_MAX  = MDC_W'(MD_MAX);
  localparam logic [MDC_W-1:0] CNT_LAST = MDC_W'(MD_MAX - 1);

  state_t                          state;
  logic [MDC_W-1:0]                md_cnt;
  logic [NUM_RD-1:0]               ex_hit, hit;
  logic [NUM_RD-1:0][DATA_W-1:0]   port_data;
  logic [NUM_LATCH-1:0][1:0]       cond_run;
  logic                            lu, md_hold;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    fwd_port_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
      .raddr      (id_raddr[k*ADDR_W +: ADDR_W]),
      .ex_waddr   (ex_waddr),
      .me_waddr   (me_waddr),
      .me_load    (me_load),
      .ex_wdata   (ex_wdata),
      .ex_hi      (ex_hi),
      .ex_lo      (ex_lo),
      .me_wdata   (me_wdata),
      .me_hi      (me_hi),
      .me_lo      (me_lo),
      .me_mem_data(me_mem_data),
      .ex_hit     (ex_hit[k]),
      .hit        (hit[k]),
      .data       (port_data[k])
    );
  end

  assign lu        = (|ex_hit) & ex_load;
  assign fwd_valid = (rst || lu) ? '0 : hit;

  always_comb begin
    fwd_data = '0;
    for (int k = 0; k < NUM_RD; k++)
      if (fwd_valid[k]) fwd_data[k*DATA_W +: DATA_W] = port_data[k];
  end

  // md_done in MULDIV releases the stall and falls through to the normal rules.
  assign md_hold = ((state == ST_MULDIV) && !md_done) || ((state == ST_NORMAL) && md_start);

  // cond_run excludes rst so reset only reaches outputs and async flop resets.
  always_comb begin
    cond_run = '0;
    for (int i = 0; i < NUM_LATCH; i++) begin
      if (cpu_stall || md_hold)      cond_run[i] = COND_STALL;
      else if (br_flush)             cond_run[i] = (i == 1 || i == 2) ? COND_ZERO : COND_FLOW;
      else if (lu)                   cond_run[i] = (i < 2) ? COND_STALL : (i == 2) ? COND_ZERO : COND_FLOW;
      else                           cond_run[i] = COND_FLOW;
    end
  end

  always_comb begin
    cond = cond_run;
    if (rst)
      for (int i = 0; i < NUM_LATCH; i++) cond[2*i +: 2] = COND_ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_NORMAL;
      md_cnt      <= '0;
      md_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      if ((cond_run[0] == COND_STALL) && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      // Counts every MULDIV cycle, including frozen ones.
      if (state == ST_MULDIV) begin
        if (md_cnt != CNT_MAX) md_cnt <= md_cnt + 1'b1;
        if (md_cnt >= CNT_LAST) md_timeout <= 1'b1;
      end
      if (!cpu_stall) begin
        if ((state == ST_MULDIV) && md_done) begin
          state <= ST_NORMAL;
        end else if ((state == ST_NORMAL) && md_start) begin
          state  <= ST_MULDIV;
          md_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Random + directed bench for hazard_fwd_unit against a rule-level model.
module tb_hazard_fwd_unit;
  import pipe_pkg::*;

  localparam int DW = 32, AW = 7, NR = 2, NL = 6, MDM = 4, CW = 2;

  logic           clk, rst, cpu_stall, ex_load, me_load, br_flush, md_start, md_done;
  logic [NR*AW-1:0] id_raddr;
  logic [AW-1:0]  ex_waddr, me_waddr;
  logic [DW-1:0]  ex_wdata, me_wdata, ex_hi, ex_lo, me_hi, me_lo, me_mem_data;
  logic [NL*2-1:0] cond;
  logic [NR-1:0]  fwd_valid;
  logic [NR*DW-1:0] fwd_data;
  logic           md_timeout;
  logic [CW-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  hazard_fwd_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_LATCH(NL),
                    .MD_MAX(MDM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall), .id_raddr(id_raddr),
    .ex_waddr(ex_waddr), .me_waddr(me_waddr), .ex_load(ex_load), .me_load(me_load),
    .ex_wdata(ex_wdata), .me_wdata(me_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .me_hi(me_hi), .me_lo(me_lo), .me_mem_data(me_mem_data), .br_flush(br_flush),
    .md_start(md_start), .md_done(md_done), .cond(cond), .fwd_valid(fwd_valid),
    .fwd_data(fwd_data), .md_timeout(md_timeout), .stall_count(stall_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic         m_md, m_to;
  int           m_cnt, m_stall;
  logic [NL*2-1:0] e_cond;
  logic [NR-1:0]   e_fv;
  logic [NR*DW-1:0] e_fd;
  logic            e_lu;

  function automatic logic hitf(input logic [AW-1:0] ra, input logic [AW-1:0] wa);
    if (ra == NULL_ADDR) return 1'b0;
    if (ra == wa) return 1'b1;
    return (wa == HILO_ADDR) && (ra == HI_ADDR || ra == LO_ADDR);
  endfunction

  function automatic logic [DW-1:0] srcf(input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                                         input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                                         input logic [DW-1:0] w);
    case (wa)
      HI_ADDR:   return hi;
      LO_ADDR:   return lo;
      HILO_ADDR: return (ra == HI_ADDR) ? hi : lo;
      default:   return w;
    endcase
  endfunction

  always_comb begin
    e_lu = 1'b0;
    e_fv = '0;
    e_fd = '0;
    for (int k = 0; k < NR; k++)
      if (ex_load && hitf(id_raddr[k*AW +: AW], ex_waddr)) e_lu = 1'b1;
    if (!rst && !e_lu)
      for (int k = 0; k < NR; k++) begin
        if (hitf(id_raddr[k*AW +: AW], ex_waddr)) begin
          e_fv[k] = 1'b1;
          e_fd[k*DW +: DW] = srcf(ex_waddr, id_raddr[k*AW +: AW], ex_hi, ex_lo, ex_wdata);
        end else if (hitf(id_raddr[k*AW +: AW], me_waddr)) begin
          e_fv[k] = 1'b1;
          e_fd[k*DW +: DW] = srcf(me_waddr, id_raddr[k*AW +: AW], me_hi, me_lo,
                                  me_load ? me_mem_data : me_wdata);
        end
      end
  end

  always_comb begin
    e_cond = '0;
    for (int i = 0; i < NL; i++) begin
      if (rst)                                    e_cond[2*i +: 2] = COND_ZERO;
      else if (cpu_stall)                         e_cond[2*i +: 2] = COND_STALL;
      else if (m_md ? !md_done : md_start)        e_cond[2*i +: 2] = COND_STALL;
      else if (br_flush)                          e_cond[2*i +: 2] = (i == 1 || i == 2) ? COND_ZERO : COND_FLOW;
      else if (e_lu)                              e_cond[2*i +: 2] = (i <= 1) ? COND_STALL : (i == 2 ? COND_ZERO : COND_FLOW);
      else                                        e_cond[2*i +: 2] = COND_FLOW;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_md <= 1'b0; m_to <= 1'b0; m_cnt <= 0; m_stall <= 0;
    end else begin
      if (e_cond[1:0] == COND_STALL && m_stall < (1 << CW) - 1) m_stall <= m_stall + 1;
      if (m_md) begin
        if (m_cnt < MDM) m_cnt <= m_cnt + 1;
        if (m_cnt + 1 >= MDM) m_to <= 1'b1;
      end
      if (!cpu_stall) begin
        if (m_md && md_done) m_md <= 1'b0;
        else if (!m_md && md_start) begin m_md <= 1'b1; m_cnt <= 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cond", 64'(cond), 64'(e_cond));
    chk("fwd_valid", 64'(fwd_valid), 64'(e_fv));
    chk("fwd_data", 64'(fwd_data), 64'(e_fd));
    chk("md_timeout", 64'(md_timeout), 64'(m_to));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    cpu_stall = 0; br_flush = 0; md_start = 0; md_done = 0;
    ex_load = 0; me_load = 0;
    id_raddr = {NULL_ADDR, NULL_ADDR};
    ex_waddr = NULL_ADDR; me_waddr = NULL_ADDR;
    ex_wdata = 0; me_wdata = 0; ex_hi = 0; ex_lo = 0; me_hi = 0; me_lo = 0; me_mem_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      8:       return HI_ADDR;
      9:       return LO_ADDR;
      10:      return HILO_ADDR;
      11:      return NULL_ADDR;
      default: return AW'(r);
    endcase
  endfunction

  initial begin
    rst = 1;
    idle();
    #2;
    chk("reset cond", 64'(cond), 64'h aaa);
    chk("reset fwd_valid", 64'(fwd_valid), 64'h0);
    chk("reset stall_count", 64'(stall_count), 64'h0);
    chk("reset md_timeout", 64'(md_timeout), 64'h0);
    step();
    rst = 0;

    // EX forward, then EX wins over MEM
    id_raddr = {NULL_ADDR, 7'd5}; ex_waddr = 7'd5; ex_wdata = 32'hAAAA_0001;
    settle();
    chk("ex fwd valid", 64'(fwd_valid), 64'h1);
    chk("ex fwd data0", 64'(fwd_data[31:0]), 64'hAAAA_0001);
    chk("ex fwd cond", 64'(cond), 64'h0);
    step();
    me_waddr = 7'd5; me_wdata = 32'hBBBB_0002;
    settle();
    chk("ex over me", 64'(fwd_data[31:0]), 64'hAAAA_0001);

    // load-use on port 1
    step();
    idle();
    id_raddr = {7'd5, NULL_ADDR}; ex_waddr = 7'd5; ex_load = 1;
    settle();
    chk("lu cond", 64'(cond), 64'h025);
    chk("lu stall_count before", 64'(stall_count), 64'h0);
    step();
    ex_waddr = NULL_ADDR; ex_load = 0; me_waddr = 7'd5; me_load = 1; me_mem_data = 32'h1234;
    settle();
    chk("lu stall_count after", 64'(stall_count), 64'h1);
    chk("me load fwd data1", 64'(fwd_data[63:32]), 64'h1234);
    chk("me load fwd valid", 64'(fwd_valid), 64'h2);

    // HILO pair from MEM
    step();
    idle();
    me_waddr = HILO_ADDR; me_hi = 32'h11; me_lo = 32'h22; id_raddr = {LO_ADDR, HI_ADDR};
    settle();
    chk("hilo fwd data", 64'(fwd_data), 64'h0000_0022_0000_0011);
    chk("hilo fwd valid", 64'(fwd_valid), 64'h3);

    // mul/div: start, 9 busy cycles, done with a load-use hazard
    step();
    idle();
    md_start = 1;
    settle();
    chk("md start cond", 64'(cond), 64'h555);
    step();
    md_start = 0;
    for (int c = 0; c < 9; c++) begin
      settle();
      chk("md busy cond", 64'(cond), 64'h555);
      step();
    end
    md_done = 1; id_raddr = {7'd5, NULL_ADDR}; ex_waddr = 7'd5; ex_load = 1;
    settle();
    chk("md done lu cond", 64'(cond), 64'h025);
    step();
    idle();
    settle();
    chk("md back normal", 64'(cond), 64'h0);
    chk("md long timeout", 64'(md_timeout), 64'h1);

    // timeout exactly at the 4th MULDIV cycle, then async reset mid-MULDIV
    step();
    rst = 1;
    #1;
    rst = 0;
    md_start = 1;
    step();
    md_start = 0;
    step(); step(); step();
    chk("timeout before", 64'(md_timeout), 64'h0);
    step();
    chk("timeout at 4", 64'(md_timeout), 64'h1);
    #2;
    rst = 1;
    #1;
    chk("async rst timeout", 64'(md_timeout), 64'h0);
    chk("async rst count", 64'(stall_count), 64'h0);
    chk("async rst cond", 64'(cond), 64'haaa);
    rst = 0;
    step();
    settle();
    chk("after rst normal", 64'(cond), 64'h0);

    // flush beats load-use; cpu_stall beats flush; saturation
    step();
    id_raddr = {7'd5, NULL_ADDR}; ex_waddr = 7'd5; ex_load = 1; br_flush = 1;
    settle();
    chk("flush cond", 64'(cond), 64'h028);
    step();
    cpu_stall = 1;
    settle();
    chk("stall over flush", 64'(cond), 64'h555);
    step();
    chk("sat count 1", 64'(stall_count), 64'h1);
    step(); step(); step(); step();
    chk("sat count 3", 64'(stall_count), 64'h3);
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      cpu_stall = ($urandom_range(0, 7) == 0);
      br_flush  = ($urandom_range(0, 5) == 0);
      md_start  = ($urandom_range(0, 7) == 0);
      md_done   = ($urandom_range(0, 5) == 0);
      ex_load   = ($urandom_range(0, 2) == 0);
      me_load   = ($urandom_range(0, 2) == 0);
      id_raddr  = {rand_addr(), rand_addr()};
      ex_waddr  = rand_addr();
      me_waddr  = rand_addr();
      ex_wdata  = $urandom; me_wdata = $urandom; ex_hi = $urandom; ex_lo = $urandom;
      me_hi     = $urandom; me_lo = $urandom; me_mem_data = $urandom;
    end
    step();
    idle();
    rst = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
